// File: rtl/mdu_pkg.sv
// mdu_pkg: op encoding, cycle defaults and decode helpers for the multiply/divide unit.
// Optional multiply-accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_pkg;
  localparam int CNT_W = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [3:0] {
    MD_NOP   = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;
  function automatic logic is_madd_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU} || is_madd_op(op);
  endfunction
  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction
  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MD_MULT, MD_DIV, MD_MADD, MD_MSUB};
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational multiplier, divider and (with MDU_MADD_EN) HI/LO accumulator.
// Operands are sign- or zero-extended so one datapath serves both signednesses.
module md_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic        sgn;
  logic        is_div;
  logic [63:0] prod;
  logic [63:0] mres;
  logic [32:0] dvd;
  logic [32:0] dvs;
  logic [32:0] quo;
  logic [32:0] rem;
  logic        unused_bits;
  assign sgn = is_signed_op(op);
  assign is_div = is_div_op(op);
  assign div_zero = is_div && b == 32'd0;
  assign prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
  // 33-bit signed divide keeps 0x80000000 / -1 representable; low word wraps as required
  assign dvd = {sgn & a[31], a};
  assign dvs = (b == 32'd0) ? 33'd1 : {sgn & b[31], b};
  assign quo = 33'($signed(dvd) / $signed(dvs));
  assign rem = 33'($signed(dvd) % $signed(dvs));
`ifdef MDU_MADD_EN
  assign mres = !is_madd_op(op) ? prod :
                op inside {MD_MSUB, MD_MSUBU} ? {hi, lo} - prod : {hi, lo} + prod;
  assign unused_bits = ^{quo[32], rem[32]};
`else
  assign mres = prod;
  assign unused_bits = ^{quo[32], rem[32], hi, lo};
`endif
  assign res_hi = is_div ? rem[31:0] : mres[63:32];
  assign res_lo = is_div ? quo[31:0] : mres[31:0];
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO; results commit when the busy count expires.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module md_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_ok;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             div_zero;
  md_arith u_arith (
    .op      (op),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .div_zero(div_zero)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        if (pend_ok) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end else if (start) begin
      if (is_mul_op(op) || is_div_op(op)) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_ok <= !div_zero;
        cnt     <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        busy    <= 1'b1;
      end else if (op == MD_MTHI) begin
        hi <= a;
      end else if (op == MD_MTLO) begin
        lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against a 64-bit arithmetic reference model.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int n_checks = 0;
  int n_fail = 0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO as one 64-bit quantity, returns the expected busy length.
  task automatic ref_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    logic [63:0] ux = {32'd0, x};
    logic [63:0] uy = {32'd0, y};
    lat = 0;
    case (o)
      4'd1: begin {m_hi, m_lo} = sx * sy; lat = MC; end
      4'd2: begin {m_hi, m_lo} = ux * uy; lat = MC; end
      4'd3: begin
        lat = DC;
        if (y != 0) begin m_lo = 32'(sx / sy); m_hi = 32'(sx % sy); end
      end
      4'd4: begin
        lat = DC;
        if (y != 0) begin m_lo = 32'(ux / uy); m_hi = 32'(ux % uy); end
      end
      4'd5: m_hi = x;
      4'd6: m_lo = x;
`ifdef MDU_MADD_EN
      4'd7:  begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sx * sy); lat = MC; end
      4'd8:  begin {m_hi, m_lo} = {m_hi, m_lo} + ux * uy; lat = MC; end
      4'd9:  begin {m_hi, m_lo} = {m_hi, m_lo} - 64'(sx * sy); lat = MC; end
      4'd10: begin {m_hi, m_lo} = {m_hi, m_lo} - ux * uy; lat = MC; end
`endif
      default: ;
    endcase
  endtask

  // Called #1 after an edge; leaves us #1 after the next edge with start dropped.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    int n;
    ref_op(o, x, y, lat);
    issue(o, x, y);
    wait_idle(n);
    check({tag, " busy cycles"}, 64'(n), 64'(lat));
    check({tag, " hi"}, 64'(hi), 64'(m_hi));
    check({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run("mthi", 4'd5, 32'h1234, 32'd0);
    check("mthi value", 64'(hi), 64'h1234);
    run("mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo", 64'(lo), 64'hFFFF_FFFA);
    run("multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu hi", 64'(hi), 64'h2);
    check("multu lo", 64'(lo), 64'hFFFF_FFFA);
    run("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div lo", 64'(lo), 64'hFFFF_FFFD);
    check("div hi", 64'(hi), 64'hFFFF_FFFF);
    run("divu by zero", 4'd4, 32'd7, 32'd0);
    check("divu0 hi kept", 64'(hi), 64'hFFFF_FFFF);
    check("divu0 lo kept", 64'(lo), 64'hFFFF_FFFD);
    run("div overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf lo", 64'(lo), 64'h8000_0000);
    check("ovf hi", 64'(hi), 64'h0);

    // MTLO while busy must be dropped
    ref_op(4'd1, 32'd6, 32'd7, lat);
    issue(4'd1, 32'd6, 32'd7);
    issue(4'd6, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    check("mtlo-in-busy remaining", 64'(n), 64'(MC - 1));
    check("mtlo-in-busy lo", 64'(lo), 64'd42);
    check("mtlo-in-busy hi", 64'(hi), 64'd0);

    // DIV issued in the first idle cycle after a MULT commits
    ref_op(4'd1, 32'd100, 32'd3, lat);
    issue(4'd1, 32'd100, 32'd3);
    wait_idle(n);
    check("b2b mult lat", 64'(n), 64'(MC));
    check("b2b mult lo", 64'(lo), 64'd300);
    ref_op(4'd3, 32'd300, 32'd7, lat);
    issue(4'd3, 32'd300, 32'd7);
    check("b2b div busy", 64'(busy), 64'd1);
    wait_idle(n);
    check("b2b div lat", 64'(n), 64'(DC));
    check("b2b div lo", 64'(lo), 64'd42);
    check("b2b div hi", 64'(hi), 64'd6);

    run("madd prep hi", 4'd5, 32'd0, 32'd0);
    run("madd prep lo", 4'd6, 32'hFFFF_FFFF, 32'd0);
    run("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu hi", 64'(hi), 64'd1);
    check("maddu lo", 64'(lo), 64'd0);
`else
    check("maddu-off hi", 64'(hi), 64'd0);
    check("maddu-off lo", 64'(lo), 64'hFFFF_FFFF);
`endif

    // Asynchronous reset with cnt=3 aborts the MULT
    run("pre-reset mtlo", 4'd6, 32'h55, 32'd0);
    issue(4'd1, 32'd5, 32'd5);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post-abort busy", 64'(busy), 64'd0);
    check("post-abort lo", 64'(lo), 64'd0);
    m_hi = '0;
    m_lo = '0;

    for (int i = 0; i < 80; i++) begin
      logic [3:0] ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 4'($urandom_range(0, 15));
      ra = pick();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
      run($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
